xor_stream_cipher: RTL and testbench

- Parametrised byte-stream XOR cipher engine. Successor to the fixed-size UART encryption top level.
- Accepts a framed request from a UART receiver: [data_len][data bytes][key_len][key bytes].
- Encrypts each data byte with a rotating key and returns [data_len][cipher bytes] through a UART sender.
- Exposes a combinational view port for LED/debug display. Sits between UART_Receiver/UART_Sender and board I/O.

---
 rtl/xor_stream_cipher.sv | 239 +++++++++++++++++++++++
 tb/tb_xor_stream_cipher.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_cipher.sv
// xor_stream_cipher: framed byte-stream XOR cipher between a UART receiver and sender.
// Request frame : [data_len][data bytes][key_len][key bytes]
// Response frame: [data_len][cipher bytes]
// Optional build macro XOR_CHAIN_EN selects chained mode:
//   cipher[i] = plain[i] ^ key[k] ^ cipher[i-1], with cipher[-1] = 8'h00.
module xor_stream_cipher #(
    parameter int DATA_DEPTH = 100,
    parameter int KEY_DEPTH  = 3,
    parameter int DATA_AW    = 7,
    parameter int KEY_AW     = 2
) (
    input  logic               Clk_100M,
    input  logic               Reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_ready,
    output logic               rx_ack,
    output logic [7:0]         tx_data,
    output logic               tx_send,
    input  logic               tx_busy,
    input  logic [DATA_AW-1:0] view_idx,
    output logic [7:0]         view_plain,
    output logic [7:0]         view_cipher,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_DATA,
        S_RX_KLEN,
        S_RX_KEY,
        S_CRYPT,
        S_TX_LEN,
        S_TX_DATA
    } state_t;

    // Per-byte transmit handshake: arm the strobe, see the sender go busy, see it finish.
    typedef enum logic [1:0] {
        TX_ARM,
        TX_WAIT_HI,
        TX_WAIT_LO
    } txph_t;

    logic [7:0]         r_plain  [DATA_DEPTH];
    logic [7:0]         r_cipher [DATA_DEPTH];
    logic [7:0]         r_key    [KEY_DEPTH];

    state_t             r_state;
    txph_t              r_tx_ph;
    logic [DATA_AW-1:0] r_data_cnt;
    logic [KEY_AW-1:0]  r_key_cnt;
    logic [7:0]         r_data_len;
    logic [7:0]         r_key_len;
    logic               r_rx_ack;
    logic               r_tx_send;
    logic [7:0]         r_tx_data;
    logic               r_done;
    logic               r_err;
`ifdef XOR_CHAIN_EN
    logic [7:0]         r_chain;
`endif

    logic               w_take;
    logic               w_data_last;
    logic               w_key_last;
    logic [7:0]         w_cipher_byte;

    // A byte is consumed only on the first cycle of a ready pulse.
    assign w_take      = rx_ready & ~r_rx_ack;
    assign w_data_last = (8'(r_data_cnt) == (r_data_len - 8'd1));
    assign w_key_last  = (8'(r_key_cnt) == (r_key_len - 8'd1));

`ifdef XOR_CHAIN_EN
    assign w_cipher_byte = r_plain[r_data_cnt] ^ r_key[r_key_cnt] ^ r_chain;
`else
    assign w_cipher_byte = r_plain[r_data_cnt] ^ r_key[r_key_cnt];
`endif

    // Buffer storage: no reset, contents survive Reset by design.
    always_ff @(posedge Clk_100M) begin
        if (r_state == S_RX_DATA && w_take) begin
            r_plain[r_data_cnt] <= rx_data;
        end
        if (r_state == S_RX_KEY && w_take) begin
            r_key[r_key_cnt] <= rx_data;
        end
        if (r_state == S_CRYPT) begin
            r_cipher[r_data_cnt] <= w_cipher_byte;
        end
`ifdef XOR_CHAIN_EN
        if (r_state == S_RX_KEY && w_take && w_key_last) begin
            r_chain <= 8'h00;
        end else if (r_state == S_CRYPT) begin
            r_chain <= w_cipher_byte;
        end
`endif
    end

    // Frame FSM with rx handshake, counters and registered outputs.
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_tx_ph    <= TX_ARM;
            r_data_cnt <= '0;
            r_key_cnt  <= '0;
            r_data_len <= 8'd0;
            r_key_len  <= 8'd0;
            r_rx_ack   <= 1'b0;
            r_tx_send  <= 1'b0;
            r_tx_data  <= 8'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_tx_send <= 1'b0;
            r_done    <= 1'b0;

            if (w_take) begin
                r_rx_ack <= 1'b1;
            end else if (r_rx_ack && !rx_ready) begin
                r_rx_ack <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        if (rx_data == 8'd0 || rx_data > 8'(DATA_DEPTH)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err      <= 1'b0;
                            r_data_len <= rx_data;
                            r_data_cnt <= '0;
                            r_state    <= S_RX_DATA;
                        end
                    end
                end
                S_RX_DATA: begin
                    if (w_take) begin
                        if (w_data_last) begin
                            r_data_cnt <= '0;
                            r_state    <= S_RX_KLEN;
                        end else begin
                            r_data_cnt <= r_data_cnt + DATA_AW'(1);
                        end
                    end
                end
                S_RX_KLEN: begin
                    if (w_take) begin
                        if (rx_data == 8'd0 || rx_data > 8'(KEY_DEPTH)) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_key_len <= rx_data;
                            r_key_cnt <= '0;
                            r_state   <= S_RX_KEY;
                        end
                    end
                end
                S_RX_KEY: begin
                    if (w_take) begin
                        if (w_key_last) begin
                            r_key_cnt  <= '0;
                            r_data_cnt <= '0;
                            r_state    <= S_CRYPT;
                        end else begin
                            r_key_cnt <= r_key_cnt + KEY_AW'(1);
                        end
                    end
                end
                S_CRYPT: begin
                    if (w_take) begin
                        r_err <= 1'b1;
                    end
                    r_key_cnt <= w_key_last ? '0 : r_key_cnt + KEY_AW'(1);
                    if (w_data_last) begin
                        r_data_cnt <= '0;
                        r_tx_ph    <= TX_ARM;
                        r_state    <= S_TX_LEN;
                    end else begin
                        r_data_cnt <= r_data_cnt + DATA_AW'(1);
                    end
                end
                S_TX_LEN, S_TX_DATA: begin
                    if (w_take) begin
                        r_err <= 1'b1;
                    end
                    case (r_tx_ph)
                        TX_ARM: begin
                            if (!tx_busy) begin
                                r_tx_send <= 1'b1;
                                r_tx_data <= (r_state == S_TX_LEN) ? r_data_len
                                                                   : r_cipher[r_data_cnt];
                                r_tx_ph   <= TX_WAIT_HI;
                            end
                        end
                        TX_WAIT_HI: begin
                            if (tx_busy) begin
                                r_tx_ph <= TX_WAIT_LO;
                            end
                        end
                        TX_WAIT_LO: begin
                            if (!tx_busy) begin
                                r_tx_ph <= TX_ARM;
                                if (r_state == S_TX_LEN) begin
                                    r_state <= S_TX_DATA;
                                end else if (w_data_last) begin
                                    r_done  <= 1'b1;
                                    r_state <= S_IDLE;
                                end else begin
                                    r_data_cnt <= r_data_cnt + DATA_AW'(1);
                                end
                            end
                        end
                        default: r_tx_ph <= TX_ARM;
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Debug view: indices outside the current frame read as zero.
    always_comb begin
        view_plain  = 8'd0;
        view_cipher = 8'd0;
        if (8'(view_idx) < r_data_len) begin
            view_plain  = r_plain[view_idx];
            view_cipher = r_cipher[view_idx];
        end
    end

    assign rx_ack  = r_rx_ack;
    assign tx_data = r_tx_data;
    assign tx_send = r_tx_send;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Bench for xor_stream_cipher: fixed frame table, hand-written corner sequences,
// and random frames compared against a byte-level reference of the cipher rules.
module tb_xor_stream_cipher;

    localparam int DATA_DEPTH = 100;
    localparam int KEY_DEPTH  = 3;
    localparam int DATA_AW    = 7;
    localparam int KEY_AW     = 2;

    logic               Clk_100M = 1'b0;
    logic               Reset    = 1'b1;
    logic [7:0]         rx_data  = 8'd0;
    logic               rx_ready = 1'b0;
    logic               rx_ack;
    logic [7:0]         tx_data;
    logic               tx_send;
    logic               tx_busy  = 1'b0;
    logic [DATA_AW-1:0] view_idx = '0;
    logic [7:0]         view_plain;
    logic [7:0]         view_cipher;
    logic               busy;
    logic               done;
    logic               err;

    xor_stream_cipher #(
        .DATA_DEPTH(DATA_DEPTH),
        .KEY_DEPTH (KEY_DEPTH),
        .DATA_AW   (DATA_AW),
        .KEY_AW    (KEY_AW)
    ) dut (
        .Clk_100M   (Clk_100M),
        .Reset      (Reset),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_ack     (rx_ack),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_busy    (tx_busy),
        .view_idx   (view_idx),
        .view_plain (view_plain),
        .view_cipher(view_cipher),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 Clk_100M = ~Clk_100M;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] txq[$];
    int         done_cnt  = 0;
    int         send_cnt  = 0;
    int         busy_left = 0;

    typedef struct packed {
        logic [7:0]        nrx;
        logic [0:15][7:0]  rx;
        logic [7:0]        ntx;
        logic [0:7][7:0]   tx;
        logic              err;
    } vec_t;

    vec_t tbl[6];

    // UART sender model: goes busy for a few cycles after every send strobe.
    always @(negedge Clk_100M) begin
        if (tx_send) begin
            txq.push_back(tx_data);
            send_cnt++;
            busy_left = 3;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        tx_busy = (busy_left > 0);
        if (done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        rx_data  = b;
        rx_ready = 1'b1;
        t = 0;
        while (!rx_ack && t < 50) begin @(negedge Clk_100M); t++; end
        if (!rx_ack) timeout_fail("rx_ack_rise");
        rx_ready = 1'b0;
        t = 0;
        while (rx_ack && t < 50) begin @(negedge Clk_100M); t++; end
        if (rx_ack) timeout_fail("rx_ack_fall");
    endtask

    task automatic load_vec(input int i);
        frame_q.delete();
        exp_q.delete();
        for (int j = 0; j < int'(tbl[i].nrx); j++) frame_q.push_back(tbl[i].rx[j]);
        for (int j = 0; j < int'(tbl[i].ntx); j++) exp_q.push_back(tbl[i].tx[j]);
    endtask

    task automatic run_frame(input string tag, input logic exp_err);
        int d0;
        int t;
        txq.delete();
        d0 = done_cnt;
        foreach (frame_q[j]) send_byte(frame_q[j]);
        if (exp_q.size() > 0) begin
            t = 0;
            while (done_cnt == d0 && t < 5000) begin @(negedge Clk_100M); t++; end
            if (done_cnt == d0) timeout_fail({tag, "_done_wait"});
        end
        repeat (4) @(negedge Clk_100M);
        chk({tag, "_ntx"}, 32'(txq.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size(); j++) begin
            chk($sformatf("%s_tx%0d", tag, j),
                (j < txq.size()) ? 32'(txq[j]) : 32'hFFFF_FFFF, 32'(exp_q[j]));
        end
        chk({tag, "_done"}, 32'(done_cnt - d0), (exp_q.size() > 0) ? 32'd1 : 32'd0);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Frame table: request bytes, expected response bytes, expected err.
        tbl[0] = {8'd7,  128'h03414243_020FF000_00000000_00000000,
`ifdef XOR_CHAIN_EN
                  8'd4,  64'h034EFCB0_00000000, 1'b0};
`else
                  8'd4,  64'h034EB24C_00000000, 1'b0};
`endif
        tbl[1] = {8'd10, 128'h05000000_00000311_22330000_00000000,
`ifdef XOR_CHAIN_EN
                  8'd6,  64'h05113300_11330000, 1'b0};
`else
                  8'd6,  64'h05112233_11220000, 1'b0};
`endif
        tbl[2] = {8'd1,  128'h00000000_00000000_00000000_00000000,
                  8'd0,  64'h0, 1'b1};
        tbl[3] = {8'd1,  128'h65000000_00000000_00000000_00000000,
                  8'd0,  64'h0, 1'b1};
        tbl[4] = {8'd4,  128'h02AABB00_00000000_00000000_00000000,
                  8'd0,  64'h0, 1'b1};
        tbl[5] = {8'd4,  128'h015A01FF_00000000_00000000_00000000,
                  8'd2,  64'h01A50000_00000000, 1'b0};

        // Reset state.
        repeat (3) @(negedge Clk_100M);
        Reset = 1'b0;
        @(negedge Clk_100M);
        chk("rst_rx_ack",  32'(rx_ack),  32'd0);
        chk("rst_tx_send", 32'(tx_send), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_err",     32'(err),     32'd0);
        chk("rst_view",    32'(view_plain), 32'd0);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            load_vec(i);
            run_frame($sformatf("tbl%0d", i), tbl[i].err);
        end

        // Reset in the middle of the response, then a fresh frame from IDLE.
        begin
            int base;
            int t;
            frame_q = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h00};
            base = send_cnt;
            foreach (frame_q[j]) send_byte(frame_q[j]);
            t = 0;
            while (send_cnt < base + 2 && t < 2000) begin @(negedge Clk_100M); t++; end
            if (send_cnt < base + 2) timeout_fail("midtx_wait");
            Reset = 1'b1;
            @(negedge Clk_100M);
            chk("midtx_busy",    32'(busy),    32'd0);
            chk("midtx_tx_send", 32'(tx_send), 32'd0);
            Reset = 1'b0;
            @(negedge Clk_100M);
            load_vec(0);
            run_frame("after_rst", 1'b0);
        end

        // View port after the basic frame.
        view_idx = 7'd1;
        #1;
        chk("view1_plain",  32'(view_plain),  32'h42);
`ifdef XOR_CHAIN_EN
        chk("view1_cipher", 32'(view_cipher), 32'hFC);
`else
        chk("view1_cipher", 32'(view_cipher), 32'hB2);
`endif
        view_idx = 7'd3;
        #1;
        chk("view3_plain",  32'(view_plain),  32'h00);
        chk("view3_cipher", 32'(view_cipher), 32'h00);

        // Random frames against the reference cipher; first one at the size limits.
        for (int f = 0; f < 10; f++) begin
            int         dlen;
            int         klen;
            logic [7:0] p[DATA_DEPTH];
            logic [7:0] k[KEY_DEPTH];
            logic [7:0] c;
`ifdef XOR_CHAIN_EN
            logic [7:0] prev;
`endif
            dlen = (f == 0) ? DATA_DEPTH : int'($urandom_range(1, 40));
            klen = (f == 0) ? KEY_DEPTH  : int'($urandom_range(1, KEY_DEPTH));
            frame_q.delete();
            exp_q.delete();
            frame_q.push_back(8'(dlen));
            for (int i = 0; i < dlen; i++) begin
                p[i] = 8'($urandom);
                frame_q.push_back(p[i]);
            end
            frame_q.push_back(8'(klen));
            for (int i = 0; i < klen; i++) begin
                k[i] = 8'($urandom);
                frame_q.push_back(k[i]);
            end
            exp_q.push_back(8'(dlen));
`ifdef XOR_CHAIN_EN
            prev = 8'h00;
`endif
            for (int i = 0; i < dlen; i++) begin
                c = p[i] ^ k[i % klen];
`ifdef XOR_CHAIN_EN
                c    = c ^ prev;
                prev = c;
`endif
                exp_q.push_back(c);
            end
            run_frame($sformatf("rand%0d", f), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
